// File: rtl/decode_pkg.sv
// Shared types and defaults for the decode strobe sequencer.
// Phase lengths are in clock cycles; a length of 0 means that phase is skipped.
package decode_pkg;

  localparam int SEL_W_DEF      = 8;
  localparam int ADDR_W         = 3;
  localparam int SETUP_CYC_DEF  = 1;
  localparam int ACTIVE_CYC_DEF = 4;
  localparam int HOLD_CYC_DEF   = 1;
  localparam int CNT_W_DEF      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACTIVE = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

  // Down-counter load value for a phase: the counter hits 0 in the phase's last cycle.
  function automatic int phase_load(input int cyc);
    return (cyc > 0) ? cyc - 1 : 0;
  endfunction

endpackage

// File: rtl/decode_strobe_seq_phase_timer.sv
// Loadable down-counter timing one sequencer phase; it parks at zero.
// zero is asserted in the last cycle of the phase that loaded it.
module phase_timer
  import decode_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/decode_strobe_seq.sv
// Captures one decode pattern per request and drives it onto the select lines with a
// SETUP -> ACTIVE -> HOLD strobe; an all-zero pattern is rejected with an error pulse.
module decode_strobe_seq
  import decode_pkg::*;
#(
  parameter int SEL_W      = SEL_W_DEF,
  parameter int SETUP_CYC  = SETUP_CYC_DEF,
  parameter int ACTIVE_CYC = ACTIVE_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_decode,
  input  logic             abort_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             strobe_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  generate
    if (ACTIVE_CYC < 1) begin : g_bad_active
      $error("decode_strobe_seq: ACTIVE_CYC must be >= 1");
    end
    if (SETUP_CYC >= (2 ** CNT_W) || ACTIVE_CYC >= (2 ** CNT_W) || HOLD_CYC >= (2 ** CNT_W)) begin : g_bad_cnt
      $error("decode_strobe_seq: phase length does not fit in CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(phase_load(SETUP_CYC));
  localparam logic [CNT_W-1:0] ACTIVE_LD = CNT_W'(phase_load(ACTIVE_CYC));
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(phase_load(HOLD_CYC));

  seq_state_t       state_reg, state_next;
  logic [SEL_W-1:0] pat_reg, pat_next;
  logic [SEL_W-1:0] sel_next;
  logic             strobe_next, busy_next, done_next, err_next;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_val;
  logic             timer_zero;
  logic [CNT_W-1:0] timer_count;
  logic             phase_end;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .zero     (timer_zero),
    .count    (timer_count)
  );

  assign phase_end = timer_zero && (timer_count == '0);
  assign req_ready = (state_reg == IDLE) && !abort_i;

  always_comb begin
    state_next     = state_reg;
    pat_next       = pat_reg;
    timer_load     = 1'b0;
    timer_load_val = '0;
    done_next      = 1'b0;
    err_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_decode == '0) begin
            err_next = 1'b1;
          end else begin
            pat_next   = req_decode;
            timer_load = 1'b1;
            if (SETUP_CYC > 0) begin
              state_next     = SETUP;
              timer_load_val = SETUP_LD;
            end else begin
              state_next     = ACTIVE;
              timer_load_val = ACTIVE_LD;
            end
          end
        end
      end
      SETUP: begin
        if (abort_i) begin
          state_next = IDLE;
        end else if (phase_end) begin
          state_next     = ACTIVE;
          timer_load     = 1'b1;
          timer_load_val = ACTIVE_LD;
        end
      end
      ACTIVE: begin
        if (abort_i) begin
          state_next = IDLE;
        end else if (phase_end) begin
          if (HOLD_CYC > 0) begin
            state_next     = HOLD;
            timer_load     = 1'b1;
            timer_load_val = HOLD_LD;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (abort_i) begin
          state_next = IDLE;
        end else if (phase_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state itself.
    sel_next    = (state_next != IDLE) ? pat_next : '0;
    strobe_next = (state_next == ACTIVE);
    busy_next   = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pat_reg   <= '0;
      sel_o     <= '0;
      strobe_o  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      sel_o     <= sel_next;
      strobe_o  <= strobe_next;
      busy_o    <= busy_next;
      done_o    <= done_next;
      err_o     <= err_next;
    end
  end

endmodule

// File: tb/tb_decode_strobe_seq.sv
// Directed bench for decode_strobe_seq: default timing (S=1 A=4 H=1) on dut_a and the
// shortest timing (S=0 A=1 H=0) on dut_b, both driven from the same inputs.
module tb_decode_strobe_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_decode;
  logic       abort_i;

  logic       ready_a, strobe_a, busy_a, done_a, err_a;
  logic [7:0] sel_a;
  logic       ready_b, strobe_b, busy_b, done_b, err_b;
  logic [7:0] sel_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_strobe_seq dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (ready_a),
    .req_decode (req_decode),
    .abort_i    (abort_i),
    .sel_o      (sel_a),
    .strobe_o   (strobe_a),
    .busy_o     (busy_a),
    .done_o     (done_a),
    .err_o      (err_a)
  );

  decode_strobe_seq #(.SETUP_CYC(0), .ACTIVE_CYC(1), .HOLD_CYC(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (ready_b),
    .req_decode (req_decode),
    .abort_i    (abort_i),
    .sel_o      (sel_b),
    .strobe_o   (strobe_b),
    .busy_o     (busy_b),
    .done_o     (done_b),
    .err_o      (err_b)
  );

  // Tuples below are {sel, strobe, busy, done, err}; cycle k is the cycle after edge k-1.
  task automatic test_reset();
    logic [11:0] got;
    rst_n = 1'b0; req_valid = 1'b0; req_decode = 8'h00; abort_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {sel_a, strobe_a, busy_a, done_a, err_a};
    n_checks++;
    if (got !== 12'h000) begin n_fail++; $display("FAIL reset_a got=%h exp=%h", got, 12'h000); end
    got = {sel_b, strobe_b, busy_b, done_b, err_b};
    n_checks++;
    if (got !== 12'h000) begin n_fail++; $display("FAIL reset_b got=%h exp=%h", got, 12'h000); end
    n_checks++;
    if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready_a); end
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_basic();
    logic [11:0] got, exp;
    @(negedge clk); req_valid = 1'b1; req_decode = 8'h0B;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_valid = 1'b0;
      @(negedge clk);
      exp = {((k <= 6) ? 8'h0B : 8'h00), (k >= 2 && k <= 5), (k <= 6), (k == 7), 1'b0};
      got = {sel_a, strobe_a, busy_a, done_a, err_a};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL basic cyc%0d got=%h exp=%h", k, got, exp); end
      n_checks++;
      if (ready_a !== (k >= 7)) begin n_fail++; $display("FAIL basic_ready cyc%0d got=%b exp=%b", k, ready_a, (k >= 7)); end
    end
    $display("basic 0B sequence checked");
  endtask

  task automatic test_err();
    logic [11:0] got, exp;
    @(negedge clk); req_valid = 1'b1; req_decode = 8'h00;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_valid = 1'b0;
      @(negedge clk);
      exp = {8'h00, 1'b0, 1'b0, 1'b0, (k == 1)};
      got = {sel_a, strobe_a, busy_a, done_a, err_a};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL err cyc%0d got=%h exp=%h", k, got, exp); end
      n_checks++;
      if (ready_a !== 1'b1) begin n_fail++; $display("FAIL err_ready cyc%0d got=%b exp=1", k, ready_a); end
    end
    $display("zero pattern rejection checked");
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, exp;
    logic [7:0]  exp_sel;
    @(negedge clk); req_valid = 1'b1; req_decode = 8'h0B;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_decode = 8'h2C;
      if (k == 8) req_valid = 1'b0;
      @(negedge clk);
      exp_sel = (k <= 6) ? 8'h0B : ((k >= 8 && k <= 13) ? 8'h2C : 8'h00);
      exp = {exp_sel, ((k >= 2 && k <= 5) || (k >= 9 && k <= 12)),
             (k <= 6 || (k >= 8 && k <= 13)), (k == 7 || k == 14), 1'b0};
      got = {sel_a, strobe_a, busy_a, done_a, err_a};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL b2b cyc%0d got=%h exp=%h", k, got, exp); end
    end
    $display("back-to-back 0B then 2C checked");
  endtask

  task automatic test_abort();
    logic [11:0] got, exp;
    @(negedge clk); req_valid = 1'b1; req_decode = 8'h0B;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_valid = 1'b0;
      if (k == 3) abort_i = 1'b1;
      if (k == 4) abort_i = 1'b0;
      @(negedge clk);
      exp = (k <= 3) ? {((k <= 3) ? 8'h0B : 8'h00), (k >= 2), 1'b1, 1'b0, 1'b0} : 12'h000;
      got = {sel_a, strobe_a, busy_a, done_a, err_a};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL abort cyc%0d got=%h exp=%h", k, got, exp); end
    end
    // Abort while idle only blocks acceptance.
    @(negedge clk); abort_i = 1'b1; req_valid = 1'b1; req_decode = 8'h11;
    #1;
    n_checks++;
    if (ready_a !== 1'b0) begin n_fail++; $display("FAIL abort_idle_ready got=%b exp=0", ready_a); end
    @(posedge clk); #1; abort_i = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    got = {sel_a, strobe_a, busy_a, done_a, err_a};
    n_checks++;
    if (got !== 12'h000) begin n_fail++; $display("FAIL abort_idle_noaccept got=%h exp=%h", got, 12'h000); end
    n_checks++;
    if (ready_a !== 1'b1) begin n_fail++; $display("FAIL abort_idle_ready_back got=%b exp=1", ready_a); end
    $display("abort in ACTIVE and in IDLE checked");
  endtask

  task automatic test_async_reset();
    logic [11:0] got;
    @(negedge clk); req_valid = 1'b1; req_decode = 8'h0B;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_valid = 1'b0;
    end
    #2;
    n_checks++;
    if (strobe_a !== 1'b1) begin n_fail++; $display("FAIL rst_pre_strobe got=%b exp=1", strobe_a); end
    rst_n = 1'b0;
    #1;
    got = {sel_a, strobe_a, busy_a, done_a, err_a};
    n_checks++;
    if (got !== 12'h000) begin n_fail++; $display("FAIL rst_async got=%h exp=%h", got, 12'h000); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      got = {sel_a, strobe_a, busy_a, done_a, err_a};
      n_checks++;
      if (got !== 12'h000) begin n_fail++; $display("FAIL rst_after cyc%0d got=%h exp=%h", k, got, 12'h000); end
    end
    n_checks++;
    if (ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_after_ready got=%b exp=1", ready_a); end
    $display("async reset mid-ACTIVE checked");
  endtask

  task automatic test_short_timing();
    logic [11:0] got, exp;
    repeat (8) @(negedge clk);
    req_valid = 1'b1; req_decode = 8'h58;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_valid = 1'b0;
      @(negedge clk);
      exp = {((k == 1) ? 8'h58 : 8'h00), (k == 1), (k == 1), (k == 2), 1'b0};
      got = {sel_b, strobe_b, busy_b, done_b, err_b};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL short cyc%0d got=%h exp=%h", k, got, exp); end
    end
    $display("S=0 A=1 H=0 sequence 58 checked");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err();
    test_back_to_back();
    repeat (4) @(negedge clk);
    test_abort();
    repeat (4) @(negedge clk);
    test_async_reset();
    test_short_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
